// File: rtl/fir_serial_ctrl.sv
// Control sequencer for a shared partly-serial FIR MAC datapath serving two
// sample channels. Each accepted sample runs TAPS MAC cycles, one final-sum
// load, and then a one-cycle registered out_valid tagged with its channel.
module fir_serial_ctrl #(
  parameter int unsigned TAP_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             ch0_valid,
  output logic             ch0_ready,
  input  logic             ch1_valid,
  output logic             ch1_ready,
  output logic             ch_sel,
  output logic             shift_en,
  output logic [TAP_W-1:0] tap_sel,
  output logic             acc_clear,
  output logic             acc_en,
  output logic             final_load,
  output logic             out_valid,
  output logic             out_ch,
  output logic             busy
);

  localparam int unsigned TAPS = 2 ** TAP_W;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic             last_ch_q, last_ch_d;
  logic             ch_sel_q, ch_sel_d;
  logic             out_valid_q;
  logic             out_ch_q;
  logic             advance;
  logic             grant;
  logic             any_valid;
  logic             grant_valid;

  // Strobes never fire while frozen or while reset is being applied.
  assign advance     = clk_enable & ~reset;
  assign any_valid   = ch0_valid | ch1_valid;
  // Sole requester wins; on contention the channel not served last wins.
  assign grant       = (ch0_valid & ch1_valid) ? ~last_ch_q : ch1_valid;
  assign grant_valid = grant ? ch1_valid : ch0_valid;

  // Next-state and datapath strobe decode.
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    last_ch_d  = last_ch_q;
    ch_sel_d   = ch_sel_q;
    ch_sel     = ch_sel_q;
    tap_sel    = tap_q;
    ch0_ready  = 1'b0;
    ch1_ready  = 1'b0;
    shift_en   = 1'b0;
    acc_en     = 1'b0;
    acc_clear  = 1'b0;
    final_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (advance && any_valid) begin
          ch0_ready = ~grant;
          ch1_ready = grant;
          if (grant_valid) begin
            shift_en  = 1'b1;
            ch_sel    = grant;
            ch_sel_d  = grant;
            last_ch_d = grant;
            tap_d     = '0;
            state_d   = S_MAC;
          end
        end
      end
      S_MAC: begin
        if (advance) begin
          acc_en    = 1'b1;
          acc_clear = (tap_q == '0);
          tap_d     = tap_q + TAP_W'(1);
          if (tap_q == LAST_TAP) begin
            state_d = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        if (advance) begin
          final_load = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter, arbiter pointer and result-tag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      last_ch_q   <= 1'b1;
      ch_sel_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= 1'b0;
    end else if (clk_enable) begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      last_ch_q   <= last_ch_d;
      ch_sel_q    <= ch_sel_d;
      out_valid_q <= (state_q == S_FINAL);
      if (state_q == S_FINAL) begin
        out_ch_q <= ch_sel_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Self-checking bench for fir_serial_ctrl: a directed vector table for the
// single-sample timeline, hand sequences for stall/reset/contention/ch1-only,
// and randomized traffic checked against a transaction-schedule model.
module tb_fir_serial_ctrl;

  localparam int unsigned TAP_W = 2;
  localparam int TAPS = 4;

  logic             clk;
  logic             reset;
  logic             clk_enable;
  logic             ch0_valid;
  logic             ch0_ready;
  logic             ch1_valid;
  logic             ch1_ready;
  logic             ch_sel;
  logic             shift_en;
  logic [TAP_W-1:0] tap_sel;
  logic             acc_clear;
  logic             acc_en;
  logic             final_load;
  logic             out_valid;
  logic             out_ch;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  fir_serial_ctrl #(.TAP_W(TAP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .ch0_valid (ch0_valid),
    .ch0_ready (ch0_ready),
    .ch1_valid (ch1_valid),
    .ch1_ready (ch1_ready),
    .ch_sel    (ch_sel),
    .shift_en  (shift_en),
    .tap_sel   (tap_sel),
    .acc_clear (acc_clear),
    .acc_en    (acc_en),
    .final_load(final_load),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a transaction is described by the enabled-cycle index at
  // which it was accepted; every output follows from the distance to it.
  bit m_active = 1'b0;
  int m_tacc   = 0;
  int m_ecnt   = 0;
  bit m_last   = 1'b1;
  bit m_chsel  = 1'b0;
  bit m_outv   = 1'b0;
  bit m_outch  = 1'b0;

  bit cur_v0, cur_v1, cur_en, cur_rst;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply inputs shortly after the clock edge and settle to mid-cycle.
  task automatic drive(input bit v0, input bit v1, input bit en, input bit rst);
    cur_v0 = v0; cur_v1 = v1; cur_en = en; cur_rst = rst;
    ch0_valid = v0; ch1_valid = v1; clk_enable = en; reset = rst;
    #4;
  endtask

  // Compare all outputs against the model, then clock and advance the model.
  task automatic check_and_advance();
    int k;
    bit mbusy, go, g, anyv, r0, r1, acc, mac, fin_now;
    k     = m_ecnt - m_tacc;
    mbusy = m_active && (k >= 1) && (k <= TAPS + 1);
    go    = cur_en && !cur_rst;
    anyv  = cur_v0 | cur_v1;
    g     = (cur_v0 && cur_v1) ? !m_last : cur_v1;
    r0    = go && !mbusy && anyv && (g == 1'b0);
    r1    = go && !mbusy && anyv && (g == 1'b1);
    acc   = (r0 && cur_v0) || (r1 && cur_v1);
    mac   = mbusy && (k <= TAPS);
    fin_now = mbusy && (k == TAPS + 1);

    chk("ch0_ready", int'(ch0_ready), int'(r0));
    chk("ch1_ready", int'(ch1_ready), int'(r1));
    chk("shift_en", int'(shift_en), int'(acc));
    chk("acc_en", int'(acc_en), int'(go && mac));
    chk("acc_clear", int'(acc_clear), int'(go && mac && (k == 1)));
    chk("final_load", int'(final_load), int'(go && fin_now));
    if (!cur_rst) begin
      chk("tap_sel", int'(tap_sel), mac ? (k - 1) : 0);
      chk("ch_sel", int'(ch_sel), int'(acc ? g : m_chsel));
      chk("busy", int'(busy), int'(mbusy));
      chk("out_valid", int'(out_valid), int'(m_outv));
      chk("out_ch", int'(out_ch), int'(m_outch));
    end

    @(posedge clk);
    if (cur_rst) begin
      m_active = 1'b0;
      m_last   = 1'b1;
      m_chsel  = 1'b0;
      m_outv   = 1'b0;
      m_outch  = 1'b0;
    end else if (cur_en) begin
      m_outv = fin_now;
      if (fin_now) m_outch = m_chsel;
      if (acc) begin
        m_tacc   = m_ecnt;
        m_active = 1'b1;
        m_last   = g;
        m_chsel  = g;
      end
      m_ecnt++;
    end
    #1;
  endtask

  task automatic cycle(input bit v0, input bit v1, input bit en, input bit rst);
    drive(v0, v1, en, rst);
    check_and_advance();
  endtask

  typedef struct {
    bit       v0;
    bit       r0;
    bit       sh;
    bit [1:0] tap;
    bit       clr;
    bit       aen;
    bit       fin;
    bit       ov;
    bit       oc;
    bit       bsy;
  } vec_t;

  vec_t vecs[7];
  int   ov_at;
  int   oc_seq[$];
  int   n_fin;
  int   n_ov;

  initial begin
    ch0_valid = 1'b0; ch1_valid = 1'b0; clk_enable = 1'b0; reset = 1'b1;
    #1;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);

    // Single-sample timeline on ch0.
    vecs[0] = '{v0:1, r0:1, sh:1, tap:0, clr:0, aen:0, fin:0, ov:0, oc:0, bsy:0};
    vecs[1] = '{v0:0, r0:0, sh:0, tap:0, clr:1, aen:1, fin:0, ov:0, oc:0, bsy:1};
    vecs[2] = '{v0:0, r0:0, sh:0, tap:1, clr:0, aen:1, fin:0, ov:0, oc:0, bsy:1};
    vecs[3] = '{v0:0, r0:0, sh:0, tap:2, clr:0, aen:1, fin:0, ov:0, oc:0, bsy:1};
    vecs[4] = '{v0:0, r0:0, sh:0, tap:3, clr:0, aen:1, fin:0, ov:0, oc:0, bsy:1};
    vecs[5] = '{v0:0, r0:0, sh:0, tap:0, clr:0, aen:0, fin:1, ov:0, oc:0, bsy:1};
    vecs[6] = '{v0:0, r0:0, sh:0, tap:0, clr:0, aen:0, fin:0, ov:1, oc:0, bsy:0};
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].v0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("vec%0d_ch0_ready", i), int'(ch0_ready), int'(vecs[i].r0));
      chk($sformatf("vec%0d_shift_en", i), int'(shift_en), int'(vecs[i].sh));
      chk($sformatf("vec%0d_tap_sel", i), int'(tap_sel), int'(vecs[i].tap));
      chk($sformatf("vec%0d_acc_clear", i), int'(acc_clear), int'(vecs[i].clr));
      chk($sformatf("vec%0d_acc_en", i), int'(acc_en), int'(vecs[i].aen));
      chk($sformatf("vec%0d_final_load", i), int'(final_load), int'(vecs[i].fin));
      chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].ov));
      chk($sformatf("vec%0d_out_ch", i), int'(out_ch), int'(vecs[i].oc));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].bsy));
      check_and_advance();
    end

    // Three-cycle stall while tap_sel shows 2 delays out_valid by 3.
    cycle(0, 0, 1, 1);
    ov_at = -1;
    cycle(1, 0, 1, 0);
    for (int i = 1; i < 20; i++) begin
      drive(1'b0, 1'b0, !(i >= 3 && i <= 5), 1'b0);
      if (i >= 3 && i <= 5) begin
        chk("stall_tap_sel", int'(tap_sel), 2);
        chk("stall_acc_en", int'(acc_en), 0);
      end
      if (out_valid && ov_at < 0) ov_at = i;
      check_and_advance();
    end
    chk("stall_out_valid_cycle", ov_at, 9);

    // Reset during MAC aborts the transaction.
    cycle(0, 0, 1, 1);
    cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    n_fin = 0; n_ov = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("abort_ch0_ready", int'(ch0_ready), 1);
    check_and_advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      if (out_valid && out_ch == 1'b0 && i < 2) n_ov++;
      check_and_advance();
    end
    chk("abort_no_early_out_valid", n_ov, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

    // Contention: both channels held valid alternate starting with ch0.
    cycle(0, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      if (i % 6 == 0) chk("contend_accept", int'(shift_en), 1);
      if (out_valid) oc_seq.push_back(int'(out_ch));
      check_and_advance();
    end
    chk("contend_results", oc_seq.size(), 3);
    if (oc_seq.size() == 3) begin
      chk("contend_out_ch0", oc_seq[0], 0);
      chk("contend_out_ch1", oc_seq[1], 1);
      chk("contend_out_ch2", oc_seq[2], 0);
    end

    // ch1 only, back-to-back.
    cycle(0, 0, 1, 1);
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      chk("ch1only_ch0_ready", int'(ch0_ready), 0);
      chk("ch1only_ch_sel", int'(ch_sel), 1);
      check_and_advance();
    end

    // Randomized traffic with stalls and occasional resets.
    cycle(0, 0, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_serial_ctrl.md
FIR_SERIAL_CTRL -- requirements
Module: fir_serial_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TAP_W, 2, tap-select width; taps per serial partition TAPS = 2**TAP_W.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_enable  in  1  global advance enable; 0 freezes all state.
- ch0_valid  in  1  channel 0 sample available.
- ch0_ready  out  1  channel 0 sample accepted this cycle when valid also high.
- ch1_valid  in  1  channel 1 sample available.
- ch1_ready  out  1  channel 1 sample accepted this cycle when valid also high.
- ch_sel  out  1  channel owning the shared MAC datapath (delay-line and accumulator bank select).
- shift_en  out  1  shift strobe for the ch_sel delay pipeline.
- tap_sel  out  TAP_W  input-mux and coefficient-mux select.
- acc_clear  out  1  accumulators load product instead of product+acc.
- acc_en  out  1  accumulator register enable.
- final_load  out  1  load partition sum into the final-sum register.
- out_valid  out  1  output register holds a new result for out_ch.
- out_ch  out  1  channel of the current result.
- busy  out  1  FSM not in IDLE.

Function
REQ-003 The block SHALL sequence one shared partly-serial MAC datapath between two sample channels using FSM states IDLE, MAC, FINAL.
REQ-004 When clk_enable=0, the FSM, counters, arbiter pointer and out_valid SHALL hold, and shift_en, acc_en, acc_clear, final_load, ch0_ready and ch1_ready SHALL be 0.
REQ-005 Arbitration, IDLE only: grant = the only valid channel; if both are valid, grant = the channel not served last (pointer last_ch).
REQ-006 In IDLE with clk_enable=1, chN_ready SHALL be 1 only for the granted channel; the ready of the other channel SHALL be 0.
REQ-007 On accept (granted valid & ready & clk_enable): shift_en=1 and ch_sel=granted channel in that same cycle; last_ch<=granted channel; next state MAC with tap counter 0.
REQ-008 MAC: tap_sel = tap counter; acc_en=1; acc_clear=1 only when tap counter=0; counter increments by 1 per enabled cycle; after counter=TAPS-1, next state FINAL.
REQ-009 FINAL: final_load=1 for one enabled cycle; acc_en=0; next state IDLE.
REQ-010 out_valid SHALL be registered: 1 for exactly one enabled cycle following FINAL, with out_ch=ch_sel of that transaction; 0 otherwise.
REQ-011 ch_sel SHALL be held constant from the accept cycle through FINAL, and SHALL hold its last value in IDLE.
REQ-012 Latency: accept at enabled cycle T -> MAC T+1..T+TAPS -> final_load T+TAPS+1 -> out_valid T+TAPS+2; the earliest next accept SHALL be T+TAPS+2, giving a throughput of TAPS+2 enabled cycles per sample.
REQ-013 Valid deasserting before ready SHALL cause no accept; a valid arriving outside IDLE SHALL wait with ready=0.
REQ-014 busy SHALL be 1 in MAC and FINAL, and 0 in IDLE.

Reset
REQ-015 On reset=1 at a clk edge (regardless of clk_enable): state=IDLE, tap counter=0, last_ch=1 (so ch0 wins the first contention), ch_sel=0, out_ch=0, out_valid=0; all strobes 0 in the following cycle.
REQ-016 Reset asserted mid-MAC or in FINAL SHALL abort the transaction with no final_load and no out_valid for it.

Verification
REQ-017 Single sample, TAP_W=2: ch0_valid=1 at cycle 0 -> ch0_ready=1 and shift_en=1 at cycle 0; tap_sel 0,1,2,3 at cycles 1-4 with acc_clear only at 1; final_load at 5; out_valid=1, out_ch=0 at 6.
REQ-018 Contention: both valid held high -> accepts alternate ch0, ch1, ch0, ... every 6 cycles; out_ch sequence 0,1,0.
REQ-019 Stall: clk_enable=0 for 3 cycles at tap_sel=2 -> tap_sel stays 2, acc_en=0 during the stall; out_valid occurs 3 cycles later than in REQ-017.
REQ-020 Reset at cycle 3 of REQ-017 -> no final_load, no out_valid; ch0_ready=1 again on the first enabled cycle after reset deasserts.
REQ-021 ch1 only valid, back-to-back -> every accept goes to ch1; ch0_ready stays 0; ch_sel=1 throughout.
